// File: rtl/priority_encoder_4to3.sv
// ---------------------------------------------------------------------------
// priority_encoder_4to3
//
// Reduces a 4-bit request vector to one registered winner index. It also
// registers a valid flag and a flag for more than one active request.
// The direction of priority is chosen at elaboration time.
//
// Parameters
//   MSB_FIRST  1: highest-numbered set bit wins
//              0: lowest-numbered set bit wins
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous reset, active-high; takes priority over en
//   en     capture enable; outputs hold while low
//   inp    request vector, bit i = request i
//   o      registered {valid, index[1:0]}
//   multi  registered, high when two or more requests were set at capture
// ---------------------------------------------------------------------------
module priority_encoder_4to3 #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] inp,
    output logic [2:0] o,
    output logic       multi
);

    logic [1:0] win_idx;
    logic       any_req;
    logic       many_req;

    always_comb begin
        win_idx = 2'd0;
        if (MSB_FIRST) begin
            casez (inp)
                4'b1???: win_idx = 2'd3;
                4'b01??: win_idx = 2'd2;
                4'b001?: win_idx = 2'd1;
                default: win_idx = 2'd0;
            endcase
        end else begin
            casez (inp)
                4'b???1: win_idx = 2'd0;
                4'b??10: win_idx = 2'd1;
                4'b?100: win_idx = 2'd2;
                4'b1000: win_idx = 2'd3;
                default: win_idx = 2'd0;
            endcase
        end
    end

    assign any_req  = |inp;

    // Clearing the lowest set bit leaves something non-zero only when at
    // least two bits were set. This avoids a full popcount.
    assign many_req = |(inp & (inp - 4'd1));

    always_ff @(posedge clk) begin
        if (rst) begin
            o     <= 3'b000;
            multi <= 1'b0;
        end else if (en) begin
            // With no request the index is forced to 0, so o reads 000.
            o     <= {any_req, win_idx};
            multi <= many_req;
        end
    end

endmodule

// File: tb/tb_priority_encoder_4to3.sv
module tb_priority_encoder_4to3;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] inp;
    logic [2:0] o_msb;
    logic [2:0] o_lsb;
    logic       multi_msb;
    logic       multi_lsb;

    int n_chk  = 0;
    int n_pass = 0;

    // Hand-computed encodings, indexed by the value of inp.
    logic [2:0] exp_msb [16] = '{3'b000, 3'b100, 3'b101, 3'b101,
                                 3'b110, 3'b110, 3'b110, 3'b110,
                                 3'b111, 3'b111, 3'b111, 3'b111,
                                 3'b111, 3'b111, 3'b111, 3'b111};
    logic [2:0] exp_lsb [16] = '{3'b000, 3'b100, 3'b101, 3'b100,
                                 3'b110, 3'b100, 3'b101, 3'b100,
                                 3'b111, 3'b100, 3'b101, 3'b100,
                                 3'b110, 3'b100, 3'b101, 3'b100};
    // multi is expected for 3, 5, 6, 7 and 9..15.
    logic [15:0] exp_multi = 16'hFEE8;

    always #5 clk = ~clk;

    priority_encoder_4to3 #(.MSB_FIRST(1'b1)) dut_msb (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inp   (inp),
        .o     (o_msb),
        .multi (multi_msb)
    );

    priority_encoder_4to3 #(.MSB_FIRST(1'b0)) dut_lsb (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .inp   (inp),
        .o     (o_lsb),
        .multi (multi_lsb)
    );

    // Values are {multi, o}.
    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got {multi,o}=%b expected %b", tag, got, exp);
        else
            n_pass++;
    endtask

    // Advance one edge and settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en  = 1'b1;
        inp = 4'b1111;

        // Reset held for two edges with all requests active.
        step();
        check("rst1_msb", {multi_msb, o_msb}, 4'b0000);
        check("rst1_lsb", {multi_lsb, o_lsb}, 4'b0000);
        step();
        check("rst2_msb", {multi_msb, o_msb}, 4'b0000);
        check("rst2_lsb", {multi_lsb, o_lsb}, 4'b0000);
        rst = 1'b0;
        step();
        check("rel_msb", {multi_msb, o_msb}, 4'b1111);
        check("rel_lsb", {multi_lsb, o_lsb}, 4'b1100);

        // Exhaustive sweep for both priority directions.
        for (int i = 0; i < 16; i++) begin
            inp = 4'(i);
            step();
            check($sformatf("sweep_msb_%0d", i), {multi_msb, o_msb}, {exp_multi[i], exp_msb[i]});
            check($sformatf("sweep_lsb_%0d", i), {multi_lsb, o_lsb}, {exp_multi[i], exp_lsb[i]});
        end

        // Outputs hold while en is low.
        inp = 4'b0100;
        step();
        check("hold_cap_msb", {multi_msb, o_msb}, 4'b0110);
        check("hold_cap_lsb", {multi_lsb, o_lsb}, 4'b0110);
        en  = 1'b0;
        inp = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("hold_msb_%0d", k), {multi_msb, o_msb}, 4'b0110);
            check($sformatf("hold_lsb_%0d", k), {multi_lsb, o_lsb}, 4'b0110);
        end
        en = 1'b1;
        step();
        check("hold_rel_msb", {multi_msb, o_msb}, 4'b0111);
        check("hold_rel_lsb", {multi_lsb, o_lsb}, 4'b0111);

        // A one-cycle reset mid-stream clears the outputs, then capture resumes.
        inp = 4'b1001;
        step();
        check("mid_pre_msb", {multi_msb, o_msb}, 4'b1111);
        check("mid_pre_lsb", {multi_lsb, o_lsb}, 4'b1100);
        rst = 1'b1;
        step();
        check("mid_rst_msb", {multi_msb, o_msb}, 4'b0000);
        check("mid_rst_lsb", {multi_lsb, o_lsb}, 4'b0000);
        rst = 1'b0;
        inp = 4'b1010;
        step();
        check("mid_res_msb", {multi_msb, o_msb}, 4'b1111);
        check("mid_res_lsb", {multi_lsb, o_lsb}, 4'b1101);

        // rst wins over en: all-ones input is ignored while reset is high.
        rst = 1'b1;
        inp = 4'b1111;
        step();
        check("rst_en_msb", {multi_msb, o_msb}, 4'b0000);
        rst = 1'b0;

        // The output must not follow inp between edges.
        inp = 4'b0000;
        step();
        check("lat_zero_msb", {multi_msb, o_msb}, 4'b0000);
        #2 inp = 4'b0001;
        #2;
        check("lat_mid_msb", {multi_msb, o_msb}, 4'b0000);
        check("lat_mid_lsb", {multi_lsb, o_lsb}, 4'b0000);
        step();
        check("lat_edge_msb", {multi_msb, o_msb}, 4'b0100);
        check("lat_edge_lsb", {multi_lsb, o_lsb}, 4'b0100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/priority_encoder_4to3.md
Name: priority_encoder_4to3

Overview:
- 4-input priority encoder with a registered 3-bit output: `o[2]` is the valid flag, `o[1:0]` is the index of the winning request.
- Also flags when more than one request is active.
- Used wherever a small request vector must be reduced to one index plus a "something requested" indication.
- Single clock domain; output registered once for timing isolation.

Parameters:
- MSB_FIRST, 1, priority direction. 1 = highest-numbered set bit wins. 0 = lowest-numbered set bit wins.

Ports:
- clk   input   1  rising-edge clock
- rst   input   1  synchronous reset, active-high
- en    input   1  capture enable; when low, outputs hold their value
- inp   input   4  request vector; bit i = request i
- o     output  3  `{valid, index[1:0]}`, registered
- multi output  1  high when two or more bits of `inp` were set at the capture edge, registered

Behaviour:
- All state updates occur on the rising edge of `clk`; no asynchronous paths.
- Reset:
  - `rst` high at a rising edge forces `o = 3'b000` and `multi = 0`.
  - `rst` has priority over `en`.
  - Reset asserted mid-operation clears the outputs on the next edge regardless of `inp`.
- Capture: with `rst` low and `en` high at a rising edge:
  - `o[2]` <= OR of `inp[3:0]`.
  - `o[1:0]` <= index of the winning set bit.
  - `multi` <= 1 if the popcount of `inp` is 2 or more, else 0.
- Hold: with `rst` low and `en` low, `o` and `multi` keep their previous values.
- Latency: exactly 1 cycle from `inp` sampled to `o` valid. No combinational path from `inp` to `o`.
- MSB_FIRST = 1 encoding (x = don't care):
  - `1xxx` -> `111`
  - `01xx` -> `110`
  - `001x` -> `101`
  - `0001` -> `100`
  - `0000` -> `000`
- MSB_FIRST = 0 encoding:
  - `xxx1` -> `100`
  - `xx10` -> `101`
  - `x100` -> `110`
  - `1000` -> `111`
  - `0000` -> `000`
- Boundary rules:
  - All-zero input yields `o = 000`. An index of 0 with valid = 0 means "no request".
  - A single-bit input always yields `multi = 0`.
  - All-ones input yields `multi = 1`.
  - X/Z on `inp` is not required to be handled; the bench drives only 0/1.
- Output width is fixed at 3 bits; the index is never wider than 2 bits.

Test Plan:
- Reset check: hold `rst` = 1 for 2 cycles with `inp = 4'b1111`, `en` = 1 -> `o = 000`, `multi = 0` after the first edge. Release `rst` -> next edge `o = 111`, `multi = 1`.
- Exhaustive sweep (MSB_FIRST = 1): `en` = 1, step `inp` 0..15, one value per cycle -> one cycle later `o` matches the table. Examples:
  - `0` -> `000`
  - `1` -> `100`
  - `2`, `3` -> `101`
  - `4`..`7` -> `110`
  - `8`..`15` -> `111`
  - `multi` high for 3, 5, 6, 7, 9..15.
- Exhaustive sweep (MSB_FIRST = 0): same stimulus. Examples:
  - `8` -> `111`
  - `12` -> `110`
  - `10` -> `101`
  - `15` -> `100`
  - `0` -> `000`
- Enable hold: capture `inp = 4'b0100` (`o = 110`), drop `en`, drive `inp = 4'b1000` for 3 cycles -> `o` stays `110`. Raise `en` -> next edge `o = 111`.
- Reset mid-stream: while sweeping with `o = 111`, assert `rst` for one cycle -> `o = 000`, `multi = 0` on that edge. Capture resumes on the following edge.
- Latency check: change `inp` from `0000` to `0001` between edges -> `o` remains `000` until the next rising edge, then becomes `100`.
